mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage in the 16-bit CPU.
- Captures one instruction per handshake: ALU result, store data, destination register and control bits.
- Loads and stores go to data memory over a req/ack handshake that may take several cycles. Execute is stalled until the access completes.
- Delivers a one-cycle writeback pulse carrying the ALU result or the loaded word.

Parameters:
- DATA_W, 16, data and address width (matches ALU result / targetAddr width).
- REG_W, 4, destination register index width.
- TIMEOUT_CYCLES, 255, maximum cycles waiting for mem_ack. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- ex_valid  input  1  execute presents an instruction this cycle
- ex_ready  output  1  stage can accept; transfer occurs when ex_valid && ex_ready
- ex_alu_result  input  DATA_W  ALU result; memory address for loads/stores
- ex_store_data  input  DATA_W  store data (reg2 of execute)
- ex_mem_read  input  1  instruction is a load
- ex_mem_write  input  1  instruction is a store
- ex_reg_write  input  1  instruction writes a register
- ex_dst_reg  input  REG_W  destination register index
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  1 = store, 0 = load
- mem_addr  output  DATA_W  memory address
- mem_wdata  output  DATA_W  store data
- mem_ack  input  1  memory completion, one-cycle pulse
- mem_rdata  input  DATA_W  load data, valid when mem_ack=1
- wb_valid  output  1  writeback pulse, one cycle per accepted instruction
- wb_reg_write  output  1  register write enable qualified by wb_valid
- wb_dst_reg  output  REG_W  destination index
- wb_data  output  DATA_W  loaded word (loads) or ALU result (others)
- mem_err  output  1  sticky timeout error; present only with MEM_TIMEOUT_EN

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset state: all outputs 0, state IDLE, ex_ready=1 on the first cycle after reset is released. Asserting reset mid-access drops mem_req the next edge and discards the held instruction; no wb_valid is produced for it.
- FSM states are IDLE, ACCESS and RESP.
  - IDLE: ex_ready=1. A transfer with no memory op latches the fields; next cycle wb_valid=1 with wb_data=ex_alu_result, and the FSM stays in IDLE, so back-to-back ALU instructions run at one per cycle. A transfer with ex_mem_read or ex_mem_write goes to ACCESS and latches the address, store data, we, dst and reg_write.
  - ACCESS: mem_req=1, ex_ready=0. mem_addr, mem_we and mem_wdata are held stable from the registered copies. When mem_ack is sampled 1, go to RESP and register mem_rdata (loads only). An ack in the first ACCESS cycle is legal.
  - RESP: wb_valid=1 for exactly one cycle with wb_data = registered rdata (load) or the address (store), mem_req=0, ex_ready=0. Next state is IDLE.
- Memory instruction latency: transfer at cycle T; mem_req from T+1; ack at T+k (k≥1); wb_valid at T+k+1; next accept at T+k+2.
- Stores: wb_reg_write is forced 0 regardless of ex_reg_write.
- ex_mem_read and ex_mem_write both 1 is illegal and is treated as a store.
- mem_ack while not in ACCESS is ignored. mem_rdata is sampled only on ack in ACCESS.
- wb_valid is never asserted while idle with no transfer. wb_reg_write, wb_dst_reg and wb_data are 0 whenever wb_valid=0.
- The writeback consumer has no backpressure; wb_valid is a pulse.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to RESP, and emit wb_valid with wb_reg_write=0 and wb_data=0.
  - Set mem_err=1. mem_err is sticky until reset.
  - An ack in the same cycle the limit is reached takes precedence as a normal completion.
- When undefined: no counter, no mem_err port, and ACCESS waits indefinitely.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with ex_valid=1 -> all outputs 0; after release ex_ready=1 and no wb_valid.
- ALU stream: 4 consecutive transfers, no mem ops, results 0x0001..0x0004, dst 1..4 -> wb_valid on 4 consecutive cycles, one cycle after each transfer, with matching data and dst; ex_ready stays 1.
- Load: addr 0x1234, dst 5, ack after 3 cycles with rdata 0xBEEF -> mem_req high 3 cycles with mem_we=0 and mem_addr=0x1234; wb_valid one cycle later with data 0xBEEF, dst 5, reg_write 1; ex_ready 0 throughout.
- Store with immediate ack: addr 0x00FF, data 0xA5A5, ack in the first ACCESS cycle -> mem_req for 1 cycle, mem_we=1, mem_wdata=0xA5A5; wb_valid with wb_reg_write=0; next accept 3 cycles after the transfer.
- Reset mid-access: rst_n low during ACCESS -> mem_req 0 next edge, no wb_valid, ex_ready=1 after release; a stray ack afterwards is ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: a load that is never acked -> mem_req drops after 4 cycles, one wb_valid with reg_write 0, mem_err=1 and held until reset.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: accepts one instruction per handshake and runs loads and stores
// over a req/ack bus. It emits a one-cycle writeback pulse. The optional MEM_TIMEOUT_EN adds an ack timeout and the sticky mem_err output.
`timescale 1ns/1ps
module mem_access_stage #(
   parameter int DATA_W         = 16,
   parameter int REG_W          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_reg_write,
   input  logic [REG_W-1:0]  ex_dst_reg,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic [REG_W-1:0]  wb_dst_reg,
`ifdef MEM_TIMEOUT_EN
   output logic              mem_err,
`endif
   output logic [DATA_W-1:0] wb_data
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic              we_q, we_d, regw_q, regw_d;
   logic [REG_W-1:0]  dst_q, dst_d;
   logic              wbv_q, wbv_d, wbrw_q, wbrw_d;
   logic [REG_W-1:0]  wbdst_q, wbdst_d;
   logic [DATA_W-1:0] wbdata_q, wbdata_d;
   logic              accept, is_mem, timeout;

   assign accept = ex_valid && ex_ready;
   assign is_mem = ex_mem_read || ex_mem_write;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // cnt_q counts completed ACCESS cycles, so the limit is hit on the TIMEOUT_CYCLES-th one
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ack;

   always_comb begin
      cnt_d = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
      err_d = err_q || ((state_q == ACCESS) && timeout);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_err = err_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && is_mem)      state_d = ACCESS;
         ACCESS:  if (mem_ack || timeout)    state_d = RESP;
         RESP:                               state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   always_comb begin
      ex_ready     = rst_n && (state_q == IDLE);
      mem_req      = (state_q == ACCESS);
      mem_we       = we_q;
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      wb_valid     = wbv_q;
      wb_reg_write = wbrw_q;
      wb_dst_reg   = wbdst_q;
      wb_data      = wbdata_q;
   end

   // Writeback fields are zero except in the single cycle wb_valid is high
   always_comb begin
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      regw_d   = regw_q;
      dst_d    = dst_q;
      wbv_d    = 1'b0;
      wbrw_d   = 1'b0;
      wbdst_d  = '0;
      wbdata_d = '0;
      if ((state_q == IDLE) && accept) begin
         if (is_mem) begin
            addr_d  = ex_alu_result;
            wdata_d = ex_store_data;
            we_d    = ex_mem_write;
            regw_d  = ex_reg_write && !ex_mem_write;
            dst_d   = ex_dst_reg;
         end else begin
            wbv_d    = 1'b1;
            wbrw_d   = ex_reg_write;
            wbdst_d  = ex_dst_reg;
            wbdata_d = ex_alu_result;
         end
      end else if ((state_q == ACCESS) && (mem_ack || timeout)) begin
         wbv_d   = 1'b1;
         wbdst_d = dst_q;
         if (mem_ack) begin
            wbrw_d   = regw_q;
            wbdata_d = we_q ? addr_q : mem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         regw_q   <= 1'b0;
         dst_q    <= '0;
         wbv_q    <= 1'b0;
         wbrw_q   <= 1'b0;
         wbdst_q  <= '0;
         wbdata_q <= '0;
      end else begin
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         regw_q   <= regw_d;
         dst_q    <= dst_d;
         wbv_q    <= wbv_d;
         wbrw_q   <= wbrw_d;
         wbdst_q  <= wbdst_d;
         wbdata_q <= wbdata_d;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_access_stage;
   localparam int DW = 16;
   localparam int RW = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_reg_write = 1'b0;
   logic [DW-1:0] ex_alu_result = '0, ex_store_data = '0, mem_rdata = '0;
   logic [RW-1:0] ex_dst_reg = '0;
   logic          mem_ack = 1'b0;
   logic          ex_ready, mem_req, mem_we, wb_valid, wb_reg_write, mem_err;
   logic [DW-1:0] mem_addr, mem_wdata, wb_data;
   logic [RW-1:0] wb_dst_reg;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   mem_access_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_dst_reg(ex_dst_reg),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dst_reg(wb_dst_reg),
`ifdef MEM_TIMEOUT_EN
      .mem_err(mem_err),
`endif
      .wb_data(wb_data)
   );
`ifndef MEM_TIMEOUT_EN
   assign mem_err = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a memory instruction is "outstanding" from acceptance until ack/timeout,
   // then the stage spends one cycle delivering its writeback before it is free again.
   bit            m_wait = 1'b0, m_resp = 1'b0, m_we = 1'b0, m_rw = 1'b0, m_err = 1'b0;
   logic [DW-1:0] m_addr = '0, m_wdata = '0;
   logic [RW-1:0] m_dst = '0;
   int            m_cyc = 0;
   bit            e_wbv = 1'b0, e_rw = 1'b0;
   logic [RW-1:0] e_dst = '0;
   logic [DW-1:0] e_data = '0;

   always @(posedge clk) begin
      bit            nv, nrw;
      logic [RW-1:0] nd;
      logic [DW-1:0] ndat;
      nv = 1'b0; nrw = 1'b0; nd = '0; ndat = '0;
      if (!rst_n) begin
         m_wait = 1'b0; m_resp = 1'b0; m_err = 1'b0; m_cyc = 0;
      end else if (m_resp) begin
         m_resp = 1'b0;
      end else if (m_wait) begin
         m_cyc = m_cyc + 1;
         if (mem_ack) begin
            nv = 1'b1; nrw = m_rw && !m_we; nd = m_dst;
            ndat = m_we ? m_addr : mem_rdata;
            m_wait = 1'b0; m_resp = 1'b1;
         end
`ifdef MEM_TIMEOUT_EN
         else if (m_cyc == TO) begin
            nv = 1'b1; nd = m_dst;
            m_err = 1'b1; m_wait = 1'b0; m_resp = 1'b1;
         end
`endif
      end else if (ex_valid) begin
         if (ex_mem_read || ex_mem_write) begin
            m_wait = 1'b1; m_cyc = 0; m_we = ex_mem_write; m_rw = ex_reg_write;
            m_addr = ex_alu_result; m_wdata = ex_store_data; m_dst = ex_dst_reg;
         end else begin
            nv = 1'b1; nrw = ex_reg_write; nd = ex_dst_reg; ndat = ex_alu_result;
         end
      end
      e_wbv = nv; e_rw = nrw; e_dst = nd; e_data = ndat;
   end

   int            req_cycles = 0, wb_count = 0;
   logic          rec_we = 1'b0, last_rw = 1'b0;
   logic [DW-1:0] rec_addr = '0, rec_wdata = '0, last_data = '0;
   logic [RW-1:0] last_dst = '0;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ex_ready", {31'd0, ex_ready}, {31'd0, rst_n && !m_wait && !m_resp});
         chk("mem_req", {31'd0, mem_req}, {31'd0, m_wait});
         if (m_wait) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
         end
         chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
         chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e_rw});
         chk("wb_dst_reg", 32'(wb_dst_reg), 32'(e_dst));
         chk("wb_data", 32'(wb_data), 32'(e_data));
`ifdef MEM_TIMEOUT_EN
         chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
`endif
         if (mem_req) begin
            req_cycles++; rec_we = mem_we; rec_addr = mem_addr; rec_wdata = mem_wdata;
         end
         if (wb_valid) begin
            wb_count++; last_data = wb_data; last_dst = wb_dst_reg; last_rw = wb_reg_write;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_in();
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
      ex_alu_result = '0; ex_store_data = '0; ex_dst_reg = '0;
   endtask

   task automatic issue(input bit rd, input bit wr, input bit rw, input logic [DW-1:0] a,
                        input logic [DW-1:0] sd, input logic [RW-1:0] d);
      ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
      ex_alu_result = a; ex_store_data = sd; ex_dst_reg = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      // Reset held 3 cycles with a load presented
      issue(1'b1, 1'b0, 1'b1, 16'h5555, 16'h0, 4'd3);
      step(); cmp_en = 1'b1;
      step(); step();
      chk("rst_ready", {31'd0, ex_ready}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
      chk("rst_wbdata", 32'(wb_data), 32'd0);
      rst_n = 1'b1; clear_in();
      step();
      chk("rel_ready", {31'd0, ex_ready}, 32'd1);
      chk("rel_wbv", {31'd0, wb_valid}, 32'd0);

      // Back-to-back ALU instructions
      base = wb_count;
      for (int i = 1; i <= 4; i++) begin
         issue(1'b0, 1'b0, 1'b1, DW'(i), 16'h0, RW'(i));
         step();
         chk("alu_ready", {31'd0, ex_ready}, 32'd1);
      end
      clear_in(); step();
      chk("alu_count", 32'(wb_count - base), 32'd4);
      chk("alu_last_data", 32'(last_data), 32'h0004);
      chk("alu_last_dst", 32'(last_dst), 32'd4);

      // Load acked on the third ACCESS cycle
      base = wb_count; req_cycles = 0;
      issue(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0, 4'd5);
      step(); clear_in();
      step(); step();
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      step(); mem_ack = 1'b0; mem_rdata = '0;
      step();
      chk("ld_req_cycles", 32'(req_cycles), 32'd3);
      chk("ld_we", {31'd0, rec_we}, 32'd0);
      chk("ld_addr", 32'(rec_addr), 32'h1234);
      chk("ld_count", 32'(wb_count - base), 32'd1);
      chk("ld_data", 32'(last_data), 32'hBEEF);
      chk("ld_dst", 32'(last_dst), 32'd5);
      chk("ld_rw", {31'd0, last_rw}, 32'd1);
      chk("ld_ready_after", {31'd0, ex_ready}, 32'd1);

      // Store acked in the first ACCESS cycle; reg_write must be suppressed
      base = wb_count; req_cycles = 0;
      issue(1'b0, 1'b1, 1'b1, 16'h00FF, 16'hA5A5, 4'd7);
      step(); clear_in();
      mem_ack = 1'b1;
      step(); mem_ack = 1'b0;
      chk("st_ready_resp", {31'd0, ex_ready}, 32'd0);
      step();
      chk("st_ready_t3", {31'd0, ex_ready}, 32'd1);
      chk("st_req_cycles", 32'(req_cycles), 32'd1);
      chk("st_we", {31'd0, rec_we}, 32'd1);
      chk("st_wdata", 32'(rec_wdata), 32'hA5A5);
      chk("st_rw", {31'd0, last_rw}, 32'd0);
      chk("st_data", 32'(last_data), 32'h00FF);

      // Read and write together behave as a store
      issue(1'b1, 1'b1, 1'b1, 16'h0042, 16'h1111, 4'd2);
      step(); clear_in();
      step(); mem_ack = 1'b1; mem_rdata = 16'h7777;
      step(); mem_ack = 1'b0; mem_rdata = '0;
      step();
      chk("rw_we", {31'd0, rec_we}, 32'd1);
      chk("rw_data", 32'(last_data), 32'h0042);
      chk("rw_rw", {31'd0, last_rw}, 32'd0);

      // Stray ack while idle must not produce a writeback
      base = wb_count;
      mem_ack = 1'b1; mem_rdata = 16'h9999;
      step(); mem_ack = 1'b0; mem_rdata = '0;
      step();
      chk("stray_idle", 32'(wb_count - base), 32'd0);

      // Reset in the middle of an access
      base = wb_count;
      issue(1'b1, 1'b0, 1'b1, 16'h2222, 16'h0, 4'd6);
      step(); clear_in();
      step();
      rst_n = 1'b0;
      step();
      chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
      chk("mid_rst_wbv", {31'd0, wb_valid}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("mid_rel_ready", {31'd0, ex_ready}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      step(); mem_ack = 1'b0; mem_rdata = '0;
      step();
      chk("mid_no_wb", 32'(wb_count - base), 32'd0);
      chk("mid_req_low", {31'd0, mem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
      // Load never acked: gives up after TO cycles
      base = wb_count; req_cycles = 0;
      issue(1'b1, 1'b0, 1'b1, 16'h3333, 16'h0, 4'd9);
      step(); clear_in();
      repeat (6) step();
      chk("to_req_cycles", 32'(req_cycles), 32'd4);
      chk("to_count", 32'(wb_count - base), 32'd1);
      chk("to_rw", {31'd0, last_rw}, 32'd0);
      chk("to_data", 32'(last_data), 32'd0);
      chk("to_err", {31'd0, mem_err}, 32'd1);
      issue(1'b0, 1'b0, 1'b1, 16'h0055, 16'h0, 4'd1);
      step(); clear_in(); step();
      chk("to_err_sticky", {31'd0, mem_err}, 32'd1);
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      chk("to_err_cleared", {31'd0, mem_err}, 32'd0);
`endif

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
